rec_play_sched: RTL and testbench
=================================

# rec_play_sched

Record/playback scheduler that owns the single external SRAM port and sequences it for the audio path. Accepts transport commands (record, play, pause, stop), maintains the record and play address pointers, and serialises one SRAM access at a time for the ADC-side writer and DAC-side reader. Applies fast/slow playback stepping and detects full-memory and end-of-recording. Sits between the per-frame audio serialiser and the SRAM pins, replacing direct pointer/memory control from switches.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample/SRAM word width
- MAX_ADDR, 2**ADDR_W-1, last writable word address
- i_clk  in  1  system clock (audio bit clock domain)
- i_rst_n  in  1  reset; one clock, synchronous, active-low
- i_cmd  in  2  0 STOP, 1 RECORD, 2 PLAY, 3 PAUSE
- i_cmd_valid  in  1  one-cycle command strobe
- i_speed  in  3  speed factor k+1 (1..8)
- i_slow  in  1  1 = slow playback, 0 = fast/normal
- i_wr_valid  in  1  writer has a sample
- i_wr_data  in  DATA_W  sample to record
- o_wr_ready  out  1  write accepted when valid & ready
- i_rd_req  in  1  reader requests next sample
- o_rd_valid  out  1  one-cycle pulse, o_rd_data valid
- o_rd_data  out  DATA_W  playback sample (registered)
- o_sram_addr  out  ADDR_W; io_sram_dq  inout  DATA_W; o_sram_oe/we/ce/lb/ub  out  1 each (active-low)
- o_state  out  3  current transport state
- o_play_addr  out  ADDR_W  current play pointer
- o_rec_end  out  ADDR_W  recording length in words
- o_full  out  1  one-cycle pulse, memory filled
- o_done  out  1  one-cycle pulse, playback reached end

## Operation
- Transport states: IDLE, REC, REC_PAUSE, PLAY, PLAY_PAUSE.
- RECORD from any state: rec_ptr←0, →REC. PAUSE: REC→REC_PAUSE, PLAY→PLAY_PAUSE; else ignored. RECORD/PLAY from matching pause resumes without pointer reset.
- PLAY from IDLE/REC*: play_ptr←0, slow_cnt←0; if rec_end==0 pulse o_done, stay IDLE; else →PLAY.
- STOP: →IDLE; when leaving REC/REC_PAUSE, rec_end←rec_ptr.
- Write: in REC with engine idle, o_wr_ready=1. On accept, write i_wr_data at rec_ptr, rec_ptr++. Access at MAX_ADDR: rec_end←MAX_ADDR+1 saturated to MAX_ADDR, pulse o_full, →IDLE.
- Read: in PLAY with engine idle, accept i_rd_req; read play_ptr, then advance. Fast (i_slow=0): play_ptr += k+1, computed ADDR_W+1 bits. Slow: slow_cnt++; when slow_cnt==k, play_ptr++, slow_cnt←0 (sample repeated k+1 times). i_speed sampled at acceptance.
- New play_ptr ≥ rec_end or carry out: pulse o_done with that read's o_rd_valid, →IDLE.
- Requests outside REC/PLAY ignored; nothing queued.
- Commands arriving mid-access: access completes (including o_rd_valid) then transition applies; state register updates immediately, engine never aborted.

## Timing
- Access engine phases A_IDLE→A_DRV→A_END→A_IDLE; one access per 3 cycles.
- Accept at edge t. Cycle t+1 (A_DRV): addr driven; write: dq driven, we_n=0; read: oe_n=0, dq Hi-Z. Cycle t+2 (A_END): we_n=1, dq/addr held; read: dq captured at end of cycle. o_rd_valid high cycle t+3, o_rd_data stable until next read.
- o_wr_ready low from t+1 through t+2.
- ce_n, lb_n, ub_n held 0 after reset.
- Reset values: state IDLE, all pointers/rec_end/slow_cnt 0, o_sram_addr 0, oe_n=1, we_n=1, dq Hi-Z, o_wr_ready/o_rd_valid/o_full/o_done 0, o_rd_data 0. Reset mid-access releases dq and deasserts we_n/oe_n next edge.

## Structure
- Package rec_play_pkg: cmd enum, transport-state enum, access-phase enum, CMD_* constants.
- Sub-module sram_port: 3-phase access engine owning SRAM pins and tristate; req/we/addr/wdata in, busy/rdata/rvalid out. Top holds transport FSM and pointers.

## Test plan
- Reset, RECORD, 5 writes 0x0001..0x0005, STOP -> addresses 0..4 written, rec_end=5, state IDLE.
- PLAY, speed k=0 fast, repeated reads -> 0x0001..0x0005 each 3 cycles after accept; o_done with 5th o_rd_valid.
- PLAY fast k=1 -> samples at addr 0,2,4 then o_done; slow k=2 -> each sample thrice, 15 valids.
- PAUSE mid-play after addr 2, then PLAY -> resumes at addr 3; STOP during A_DRV of read -> o_rd_valid still issued, then IDLE.
- Force rec_ptr near MAX_ADDR (ADDR_W=4) -> 16th write pulses o_full, o_wr_ready low, state IDLE.
- PLAY with rec_end=0 -> immediate o_done, no SRAM strobe; reset asserted during write A_DRV -> we_n=1, dq Hi-Z next edge.

Source files
------------

// File: rtl/rec_play_pkg.sv
// Shared types for the record/playback scheduler: transport commands,
// transport states and the phases of the single-port SRAM access engine.
package rec_play_pkg;

   typedef enum logic [1:0] {
      CMD_STOP   = 2'd0,
      CMD_RECORD = 2'd1,
      CMD_PLAY   = 2'd2,
      CMD_PAUSE  = 2'd3
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_REC        = 3'd1,
      ST_REC_PAUSE  = 3'd2,
      ST_PLAY       = 3'd3,
      ST_PLAY_PAUSE = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      A_IDLE = 2'd0,
      A_DRV  = 2'd1,
      A_END  = 2'd2
   } phase_e;

endpackage

// File: rtl/sram_port.sv
// Three-phase asynchronous SRAM access engine: one read or write per three
// clocks, owning the address/strobe pins and the bidirectional data bus.
module sram_port
   import rec_play_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_busy,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   output logic [ADDR_W-1:0] o_sram_addr,
   inout  wire  [DATA_W-1:0] io_sram_dq,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic              o_sram_ce_n,
   output logic              o_sram_lb_n,
   output logic              o_sram_ub_n
);

   phase_e            phase_q, phase_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              is_wr_q, is_wr_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;
   logic              dq_oe_q, dq_oe_d;
   logic              rvalid_q, rvalid_d;

   always_comb begin
      phase_d  = phase_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      is_wr_d  = is_wr_q;
      we_n_d   = we_n_q;
      oe_n_d   = oe_n_q;
      dq_oe_d  = dq_oe_q;
      rvalid_d = 1'b0;
      case (phase_q)
         A_IDLE: begin
            if (i_req) begin
               phase_d = A_DRV;
               addr_d  = i_addr;
               wdata_d = i_wdata;
               is_wr_d = i_we;
               we_n_d  = !i_we;
               oe_n_d  = i_we;
               dq_oe_d = i_we;
            end
         end
         A_DRV: begin
            // Write strobe ends here; data and address stay put for hold time.
            phase_d = A_END;
            we_n_d  = 1'b1;
         end
         A_END: begin
            phase_d = A_IDLE;
            oe_n_d  = 1'b1;
            dq_oe_d = 1'b0;
            if (!is_wr_q) begin
               rdata_d  = io_sram_dq;
               rvalid_d = 1'b1;
            end
         end
         default: phase_d = A_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         phase_q  <= A_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         is_wr_q  <= 1'b0;
         we_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         dq_oe_q  <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         is_wr_q  <= is_wr_d;
         we_n_q   <= we_n_d;
         oe_n_q   <= oe_n_d;
         dq_oe_q  <= dq_oe_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign io_sram_dq  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
   assign o_busy      = (phase_q != A_IDLE);
   assign o_rdata     = rdata_q;
   assign o_rvalid    = rvalid_q;
   assign o_sram_addr = addr_q;
   assign o_sram_oe_n = oe_n_q;
   assign o_sram_we_n = we_n_q;
   assign o_sram_ce_n = 1'b0;
   assign o_sram_lb_n = 1'b0;
   assign o_sram_ub_n = 1'b0;

endmodule

// File: rtl/rec_play_sched.sv
// Record/playback transport scheduler: owns the record and play pointers and
// serialises writer and reader traffic through a single SRAM access engine.
module rec_play_sched
   import rec_play_pkg::*;
#(
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = 16,
   parameter int MAX_ADDR = 2**ADDR_W-1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_cmd,
   input  logic              i_cmd_valid,
   input  logic [2:0]        i_speed,
   input  logic              i_slow,
   input  logic              i_wr_valid,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   input  logic              i_rd_req,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic [ADDR_W-1:0] o_sram_addr,
   inout  wire  [DATA_W-1:0] io_sram_dq,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic              o_sram_ce_n,
   output logic              o_sram_lb_n,
   output logic              o_sram_ub_n,
   output logic [2:0]        o_state,
   output logic [ADDR_W-1:0] o_play_addr,
   output logic [ADDR_W-1:0] o_rec_end,
   output logic              o_full,
   output logic              o_done
);

   localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

   state_e            state_q, state_d, st_mid;
   logic [ADDR_W-1:0] rec_ptr_q, rec_ptr_d;
   logic [ADDR_W-1:0] play_ptr_q, play_ptr_d;
   logic [ADDR_W-1:0] rec_end_q, rec_end_d;
   logic [2:0]        slow_cnt_q, slow_cnt_d;
   logic              done_pend_q, done_pend_d;
   logic              cmd_done_q, cmd_done_d;
   logic              full_q, full_d;
   logic [ADDR_W:0]   nxt;
   logic              acc_req, acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic              busy, rvalid, wr_ready, rd_ok;

   assign wr_ready = (state_q == ST_REC) && !busy;
   assign rd_ok    = (state_q == ST_PLAY) && !busy && i_rd_req;

   always_comb begin
      state_d     = state_q;
      rec_ptr_d   = rec_ptr_q;
      play_ptr_d  = play_ptr_q;
      rec_end_d   = rec_end_q;
      slow_cnt_d  = slow_cnt_q;
      done_pend_d = done_pend_q && !rvalid;
      cmd_done_d  = 1'b0;
      full_d      = 1'b0;
      nxt         = {1'b0, play_ptr_q};
      acc_req     = 1'b0;
      acc_we      = 1'b0;
      acc_addr    = play_ptr_q;

      if (i_wr_valid && wr_ready) begin
         acc_req  = 1'b1;
         acc_we   = 1'b1;
         acc_addr = rec_ptr_q;
         if (rec_ptr_q == MAX_A) begin
            rec_end_d = MAX_A;
            full_d    = 1'b1;
            state_d   = ST_IDLE;
         end else begin
            rec_ptr_d = rec_ptr_q + ADDR_W'(1);
         end
      end else if (rd_ok) begin
         acc_req = 1'b1;
         // Extra top bit catches a fast step that runs off the end of memory.
         if (!i_slow) begin
            nxt = {1'b0, play_ptr_q} + (ADDR_W+1)'(i_speed) + (ADDR_W+1)'(1);
         end else if (slow_cnt_q >= i_speed) begin
            nxt        = {1'b0, play_ptr_q} + (ADDR_W+1)'(1);
            slow_cnt_d = 3'd0;
         end else begin
            slow_cnt_d = slow_cnt_q + 3'd1;
         end
         play_ptr_d = nxt[ADDR_W-1:0];
         if (nxt[ADDR_W] || (nxt[ADDR_W-1:0] >= rec_end_q)) begin
            done_pend_d = 1'b1;
            state_d     = ST_IDLE;
         end
      end

      // Commands act on the state as already updated by this cycle's access.
      st_mid = state_d;
      if (i_cmd_valid) begin
         case (cmd_e'(i_cmd))
            CMD_STOP: begin
               if (st_mid == ST_REC || st_mid == ST_REC_PAUSE) rec_end_d = rec_ptr_d;
               state_d = ST_IDLE;
            end
            CMD_RECORD: begin
               if (st_mid != ST_REC_PAUSE) rec_ptr_d = '0;
               state_d = ST_REC;
            end
            CMD_PLAY: begin
               if (st_mid == ST_PLAY_PAUSE) begin
                  state_d = ST_PLAY;
               end else if (st_mid != ST_PLAY) begin
                  play_ptr_d = '0;
                  slow_cnt_d = 3'd0;
                  if (rec_end_d == '0) begin
                     cmd_done_d = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     state_d = ST_PLAY;
                  end
               end
            end
            CMD_PAUSE: begin
               if (st_mid == ST_REC)       state_d = ST_REC_PAUSE;
               else if (st_mid == ST_PLAY) state_d = ST_PLAY_PAUSE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         rec_ptr_q   <= '0;
         play_ptr_q  <= '0;
         rec_end_q   <= '0;
         slow_cnt_q  <= 3'd0;
         done_pend_q <= 1'b0;
         cmd_done_q  <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rec_ptr_q   <= rec_ptr_d;
         play_ptr_q  <= play_ptr_d;
         rec_end_q   <= rec_end_d;
         slow_cnt_q  <= slow_cnt_d;
         done_pend_q <= done_pend_d;
         cmd_done_q  <= cmd_done_d;
         full_q      <= full_d;
      end
   end

   sram_port #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_port (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req       (acc_req),
      .i_we        (acc_we),
      .i_addr      (acc_addr),
      .i_wdata     (i_wr_data),
      .o_busy      (busy),
      .o_rdata     (o_rd_data),
      .o_rvalid    (rvalid),
      .o_sram_addr (o_sram_addr),
      .io_sram_dq  (io_sram_dq),
      .o_sram_oe_n (o_sram_oe_n),
      .o_sram_we_n (o_sram_we_n),
      .o_sram_ce_n (o_sram_ce_n),
      .o_sram_lb_n (o_sram_lb_n),
      .o_sram_ub_n (o_sram_ub_n)
   );

   // The final read of a recording raises o_done together with its data.
   assign o_done      = cmd_done_q || (rvalid && done_pend_q);
   assign o_rd_valid  = rvalid;
   assign o_wr_ready  = wr_ready;
   assign o_state     = state_q;
   assign o_play_addr = play_ptr_q;
   assign o_rec_end   = rec_end_q;
   assign o_full      = full_q;

endmodule

// File: tb/tb_rec_play_sched.sv
// Bench for rec_play_sched with a 16-word SRAM model and a playback-sequence
// reference built directly from the transport rules.
`timescale 1ns/1ps
module tb_rec_play_sched;
   import rec_play_pkg::*;

   localparam int AW   = 4;
   localparam int DW   = 16;
   localparam int MAXA = 15;

   logic          clk = 1'b0;
   logic          rst_n, cmd_valid, slow, wr_valid, wr_ready, rd_req, rd_valid;
   logic [1:0]    cmd;
   logic [2:0]    speed, state;
   logic [DW-1:0] wr_data, rd_data;
   logic [AW-1:0] sram_addr, play_addr, rec_end;
   wire  [DW-1:0] sram_dq;
   logic          oe_n, we_n, ce_n, lb_n, ub_n, full, done;

   logic [DW-1:0] sram    [0:MAXA];
   logic [DW-1:0] ref_mem [0:MAXA];
   int            exp_addr[$];
   int            errors = 0;
   int            checks = 0;
   int            strobes = 0;

   always #5 clk = ~clk;

   rec_play_sched #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(MAXA)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd(cmd), .i_cmd_valid(cmd_valid),
      .i_speed(speed), .i_slow(slow), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
      .o_wr_ready(wr_ready), .i_rd_req(rd_req), .o_rd_valid(rd_valid),
      .o_rd_data(rd_data), .o_sram_addr(sram_addr), .io_sram_dq(sram_dq),
      .o_sram_oe_n(oe_n), .o_sram_we_n(we_n), .o_sram_ce_n(ce_n),
      .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n), .o_state(state),
      .o_play_addr(play_addr), .o_rec_end(rec_end), .o_full(full), .o_done(done)
   );

   // Asynchronous SRAM model
   assign sram_dq = (!oe_n && we_n && !ce_n) ? sram[sram_addr] : {DW{1'bz}};
   always @(posedge clk) if (!we_n && !ce_n) sram[sram_addr] <= sram_dq;
   always @(negedge clk) if (!oe_n || !we_n) strobes++;

   // Addresses read back, in order, for one playback run
   function automatic void build_seq(input int k, input bit slw, input int len);
      exp_addr.delete();
      if (slw) begin
         for (int a = 0; a < len; a++)
            for (int r = 0; r <= k; r++) exp_addr.push_back(a);
      end else begin
         for (int a = 0; a < len; a += k + 1) exp_addr.push_back(a);
      end
   endfunction

   task automatic send_cmd(input cmd_e c);
      cmd = c; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic do_write(input logic [DW-1:0] d, output bit ok);
      int n = 0;
      while (!wr_ready && n < 8) begin @(negedge clk); n++; end
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++; ok = 1'b0;
         $display("FAIL wr_ready_wait: o_wr_ready=%0b after %0d cycles, required 1", wr_ready, n);
      end else begin
         wr_valid = 1'b1; wr_data = d;
         @(negedge clk);
         wr_valid = 1'b0; ok = 1'b1;
      end
   endtask

   task automatic do_read(input logic [DW-1:0] exp_d, input logic exp_done, input string tag);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++; $display("FAIL %s_early_valid: o_rd_valid=%0b, required 0", tag, rd_valid);
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
         errors++;
         $display("FAIL %s_data: valid=%0b data=%h, required valid=1 data=%h", tag, rd_valid, rd_data, exp_d);
      end
      checks++;
      if (done !== exp_done) begin
         errors++; $display("FAIL %s_done: o_done=%0b, required %0b", tag, done, exp_done);
      end
   endtask

   task automatic play_check(input int k, input bit slw, input int len, input string tag);
      speed = 3'(k); slow = slw;
      build_seq(k, slw, len);
      send_cmd(CMD_PLAY);
      checks++;
      if (state !== ST_PLAY) begin
         errors++; $display("FAIL %s_state_play: state=%0d, required %0d", tag, state, ST_PLAY);
      end
      foreach (exp_addr[i]) do_read(ref_mem[exp_addr[i]], i == exp_addr.size() - 1, tag);
      checks++;
      if (state !== ST_IDLE) begin
         errors++; $display("FAIL %s_state_end: state=%0d, required 0", tag, state);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd = 2'd0; cmd_valid = 1'b0; speed = 3'd0; slow = 1'b0;
      wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (state !== 3'd0 || play_addr !== '0 || rec_end !== '0) begin
         errors++; $display("FAIL reset_regs: state=%0d play=%0d rec_end=%0d, required 0 0 0", state, play_addr, rec_end);
      end
      checks++;
      if (oe_n !== 1'b1 || we_n !== 1'b1 || sram_addr !== '0) begin
         errors++; $display("FAIL reset_strobes: oe_n=%0b we_n=%0b addr=%0d, required 1 1 0", oe_n, we_n, sram_addr);
      end
      checks++;
      if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || full !== 1'b0 || done !== 1'b0 || rd_data !== '0) begin
         errors++; $display("FAIL reset_outs: rdy=%0b rv=%0b full=%0b done=%0b rd=%h, required all 0", wr_ready, rd_valid, full, done, rd_data);
      end
      checks++;
      if (ce_n !== 1'b0 || lb_n !== 1'b0 || ub_n !== 1'b0) begin
         errors++; $display("FAIL reset_enables: ce=%0b lb=%0b ub=%0b, required 0 0 0", ce_n, lb_n, ub_n);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_empty_play();
      int s0 = strobes;
      send_cmd(CMD_PLAY);
      checks++;
      if (done !== 1'b1 || state !== ST_IDLE) begin
         errors++; $display("FAIL empty_done: done=%0b state=%0d, required 1 0", done, state);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b0 || strobes != s0) begin
         errors++; $display("FAIL empty_no_access: done=%0b strobes=%0d, required 0 0", done, strobes - s0);
      end
   endtask

   task automatic test_record();
      bit ok;
      send_cmd(CMD_RECORD);
      checks++;
      if (state !== ST_REC || wr_ready !== 1'b1) begin
         errors++; $display("FAIL rec_enter: state=%0d ready=%0b, required %0d 1", state, wr_ready, ST_REC);
      end
      for (int i = 0; i < 5; i++) begin
         do_write(16'(i + 1), ok);
         ref_mem[i] = 16'(i + 1);
         if (i == 0) begin
            checks++;
            if (wr_ready !== 1'b0 || we_n !== 1'b0 || sram_addr !== 4'd0) begin
               errors++; $display("FAIL rec_drv: ready=%0b we_n=%0b addr=%0d, required 0 0 0", wr_ready, we_n, sram_addr);
            end
            @(negedge clk);
            checks++;
            if (wr_ready !== 1'b0 || we_n !== 1'b1) begin
               errors++; $display("FAIL rec_end_phase: ready=%0b we_n=%0b, required 0 1", wr_ready, we_n);
            end
         end
      end
      send_cmd(CMD_STOP);
      checks++;
      if (rec_end !== 4'd5 || state !== ST_IDLE) begin
         errors++; $display("FAIL rec_stop: rec_end=%0d state=%0d, required 5 0", rec_end, state);
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (sram[i] !== ref_mem[i]) begin
            errors++; $display("FAIL rec_mem%0d: sram=%h, required %h", i, sram[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_pause_resume();
      int nv = 0;
      speed = 3'd0; slow = 1'b0;
      send_cmd(CMD_PLAY);
      for (int a = 0; a < 3; a++) do_read(ref_mem[a], 1'b0, "pause_pre");
      send_cmd(CMD_PAUSE);
      checks++;
      if (state !== ST_PLAY_PAUSE || play_addr !== 4'd3) begin
         errors++; $display("FAIL pause_state: state=%0d play=%0d, required %0d 3", state, play_addr, ST_PLAY_PAUSE);
      end
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      repeat (4) begin if (rd_valid) nv++; @(negedge clk); end
      checks++;
      if (nv != 0) begin
         errors++; $display("FAIL pause_ignores_req: valids=%0d, required 0", nv);
      end
      send_cmd(CMD_PLAY);
      checks++;
      if (state !== ST_PLAY || play_addr !== 4'd3) begin
         errors++; $display("FAIL resume_state: state=%0d play=%0d, required %0d 3", state, play_addr, ST_PLAY);
      end
      do_read(ref_mem[3], 1'b0, "resume");
      send_cmd(CMD_STOP);
   endtask

   task automatic test_stop_mid_read();
      speed = 3'd0; slow = 1'b0;
      send_cmd(CMD_PLAY);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0; cmd = CMD_STOP; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (state !== ST_IDLE) begin
         errors++; $display("FAIL stop_mid_state: state=%0d, required 0", state);
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[0] || done !== 1'b0) begin
         errors++; $display("FAIL stop_mid_read: valid=%0b data=%h done=%0b, required 1 %h 0", rd_valid, rd_data, done, ref_mem[0]);
      end
   endtask

   task automatic test_random_runs();
      bit ok;
      for (int it = 0; it < 3; it++) begin
         int len = $urandom_range(1, 15);
         int k   = $urandom_range(0, 7);
         bit slw = 1'($urandom_range(0, 1));
         send_cmd(CMD_RECORD);
         for (int i = 0; i < len; i++) begin
            logic [DW-1:0] d = 16'($urandom);
            do_write(d, ok);
            ref_mem[i] = d;
         end
         send_cmd(CMD_STOP);
         checks++;
         if (rec_end !== 4'(len)) begin
            errors++; $display("FAIL rand%0d_rec_end: rec_end=%0d, required %0d", it, rec_end, len);
         end
         play_check(k, slw, len, $sformatf("rand%0d_k%0d_s%0d", it, k, slw));
      end
   endtask

   task automatic test_full();
      bit ok;
      int bad = 0;
      repeat (3) @(negedge clk);
      send_cmd(CMD_RECORD);
      for (int i = 0; i <= MAXA; i++) begin
         logic [DW-1:0] d = 16'($urandom);
         do_write(d, ok);
         ref_mem[i] = d;
         if (i == MAXA - 1) begin
            checks++;
            if (full !== 1'b0) begin
               errors++; $display("FAIL full_early: o_full=%0b, required 0", full);
            end
         end
      end
      checks++;
      if (full !== 1'b1 || wr_ready !== 1'b0 || state !== ST_IDLE || rec_end !== 4'(MAXA)) begin
         errors++; $display("FAIL full_pulse: full=%0b ready=%0b state=%0d rec_end=%0d, required 1 0 0 %0d", full, wr_ready, state, rec_end, MAXA);
      end
      @(negedge clk);
      checks++;
      if (full !== 1'b0 || wr_ready !== 1'b0) begin
         errors++; $display("FAIL full_one_cycle: full=%0b ready=%0b, required 0 0", full, wr_ready);
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i <= MAXA; i++) if (sram[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL full_mem: %0d words differ, required 0", bad);
      end
   endtask

   task automatic test_reset_mid_write();
      bit ok;
      send_cmd(CMD_RECORD);
      do_write(16'hA5C3, ok);
      checks++;
      if (we_n !== 1'b0 || dut.u_port.dq_oe_q !== 1'b1) begin
         errors++; $display("FAIL rst_write_active: we_n=%0b dq_oe=%0b, required 0 1", we_n, dut.u_port.dq_oe_q);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (we_n !== 1'b1 || oe_n !== 1'b1 || dut.u_port.dq_oe_q !== 1'b0) begin
         errors++; $display("FAIL rst_mid_write: we_n=%0b oe_n=%0b dq_oe=%0b, required 1 1 0", we_n, oe_n, dut.u_port.dq_oe_q);
      end
      checks++;
      if (state !== ST_IDLE || wr_ready !== 1'b0 || rec_end !== '0) begin
         errors++; $display("FAIL rst_mid_state: state=%0d ready=%0b rec_end=%0d, required 0 0 0", state, wr_ready, rec_end);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_empty_play();
      test_record();
      play_check(0, 1'b0, 5, "fast_k0");
      play_check(1, 1'b0, 5, "fast_k1");
      play_check(2, 1'b1, 5, "slow_k2");
      test_pause_resume();
      test_stop_mid_read();
      test_random_runs();
      test_full();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
